// File: rtl/issue_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// issue_pkg
//   Shared types and constants for the issue scoreboard and its per-unit
//   latency trackers.
//   - unit_e      : encoding of the issue_unit input (0=ALU 1=LD 2=MUL 3=DIV)
//   - *_BIT       : bit position of each unit in dispatch_start / wr_allow /
//                   wb_busy (ALU is the MSB, DIV the LSB)
//   - fu_state_e  : per-unit tracker state
//   - unit_onehot : maps a unit code onto its one-hot bit-vector position
// ---------------------------------------------------------------------------
package issue_pkg;

  localparam int REG_W = 4;
  localparam int NREG  = 16;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LD  = 2'd1,
    UNIT_MUL = 2'd2,
    UNIT_DIV = 2'd3
  } unit_e;

  localparam int ALU_BIT = 3;
  localparam int LD_BIT  = 2;
  localparam int MUL_BIT = 1;
  localparam int DIV_BIT = 0;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_EXEC = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  // The unit code counts up from ALU while the bit vectors count down from
  // ALU, so the mapping goes through the named bit constants.
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    logic [3:0] oh;
    oh = 4'b0000;
    case (unit_e'(unit))
      UNIT_ALU: oh[ALU_BIT] = 1'b1;
      UNIT_LD:  oh[LD_BIT]  = 1'b1;
      UNIT_MUL: oh[MUL_BIT] = 1'b1;
      UNIT_DIV: oh[DIV_BIT] = 1'b1;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/issue_scoreboard_fu_tracker.sv
// ---------------------------------------------------------------------------
// fu_tracker
//   Tracks one functional unit: IDLE -> EXEC (LAT cycles) -> DONE, then
//   hands the result to the EXE/WB slot as soon as that slot is free.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     start       accept pulse for this unit (only honoured while idle)
//     rd          destination register captured on start
//     wb_busy     EXE/WB slot of this unit still occupied
//     idle        unit can take a new operation this cycle
//     wr_allow    result handed over this cycle (DONE and slot free)
//     rd_out      destination register of the current/last operation
// ---------------------------------------------------------------------------
module fu_tracker
  import issue_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REG_W-1:0] rd,
  input  logic             wb_busy,
  output logic             idle,
  output logic             wr_allow,
  output logic [REG_W-1:0] rd_out
);

  fu_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [REG_W-1:0] rd_q, rd_d;

  assign idle     = (state_q == FU_IDLE);
  assign wr_allow = (state_q == FU_DONE) && !wb_busy;
  assign rd_out   = rd_q;

  // Next-state logic: the counter is loaded with LAT-1 so that EXEC lasts
  // exactly LAT cycles before DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      FU_IDLE: begin
        if (start) begin
          state_d = FU_EXEC;
          cnt_d   = 4'(LAT - 1);
          rd_d    = rd;
        end else begin
          state_d = FU_IDLE;
        end
      end
      FU_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = FU_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FU_DONE: begin
        // Backpressure: stay in DONE (Rd held) while the slot is occupied.
        if (!wb_busy) begin
          state_d = FU_IDLE;
        end else begin
          state_d = FU_DONE;
        end
      end
      default: begin
        state_d = FU_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FU_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= {REG_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//   Issue stage: accepts one decoded instruction per cycle when the target
//   unit is idle and there is no RAW/WAW hazard against the 16-entry pending
//   scoreboard, starts the unit, and releases each unit's result to its
//   EXE/WB slot once the unit latency has elapsed. The writeback port clears
//   pending bits.
//   Ports:
//     clk, rst_n               clock, synchronous active-low reset
//     issue_valid/unit/rd/rn/rm/use_rn/use_rm   decoded instruction
//     issue_ready              instruction accepted if issue_valid
//     dispatch_start[3:0]      start pulse per unit ([3]=ALU .. [0]=DIV)
//     wr_allow[3:0]            result ready for the unit's EXE/WB slot
//     alu_rd/ld_rd/mul_rd/div_rd   Rd held by each unit
//     wb_busy[3:0]             EXE/WB slot still occupied
//     wb_valid, wb_rd          writeback retiring wb_rd
//     pending[15:0]            bit r set = write to r outstanding
// ---------------------------------------------------------------------------
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned LD_LAT  = 2,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_unit,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] issue_rn,
  input  logic [REG_W-1:0] issue_rm,
  input  logic             issue_use_rn,
  input  logic             issue_use_rm,
  output logic             issue_ready,
  output logic [3:0]       dispatch_start,
  output logic [3:0]       wr_allow,
  output logic [REG_W-1:0] alu_rd,
  output logic [REG_W-1:0] ld_rd,
  output logic [REG_W-1:0] mul_rd,
  output logic [REG_W-1:0] div_rd,
  input  logic [3:0]       wb_busy,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  output logic [NREG-1:0]  pending
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_mask_s, clr_mask_s;
  logic [3:0]      unit_oh_s, unit_idle_s;
  logic            unit_free_s, src_hazard_s, accept_s;

  // Hazard checks look only at registered state: a writeback clear in this
  // cycle does not unblock an instruction until the next cycle.
  assign unit_oh_s    = unit_onehot(issue_unit);
  assign unit_free_s  = |(unit_oh_s & unit_idle_s);
  assign src_hazard_s = (issue_use_rn && pending_q[issue_rn])
                     || (issue_use_rm && pending_q[issue_rm]);
  assign issue_ready  = unit_free_s && !pending_q[issue_rd] && !src_hazard_s;
  assign accept_s     = issue_valid && issue_ready;

  assign dispatch_start = accept_s ? unit_oh_s : 4'b0000;

  // Set is applied after clear so a same-register set wins.
  assign clr_mask_s = wb_valid ? (ONE_HOT0 << wb_rd)    : {NREG{1'b0}};
  assign set_mask_s = accept_s ? (ONE_HOT0 << issue_rd) : {NREG{1'b0}};
  assign pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  assign pending    = pending_q;

  // Pending-register scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  fu_tracker #(.LAT(ALU_LAT)) u_alu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dispatch_start[ALU_BIT]),
    .rd       (issue_rd),
    .wb_busy  (wb_busy[ALU_BIT]),
    .idle     (unit_idle_s[ALU_BIT]),
    .wr_allow (wr_allow[ALU_BIT]),
    .rd_out   (alu_rd)
  );

  fu_tracker #(.LAT(LD_LAT)) u_ld (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dispatch_start[LD_BIT]),
    .rd       (issue_rd),
    .wb_busy  (wb_busy[LD_BIT]),
    .idle     (unit_idle_s[LD_BIT]),
    .wr_allow (wr_allow[LD_BIT]),
    .rd_out   (ld_rd)
  );

  fu_tracker #(.LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dispatch_start[MUL_BIT]),
    .rd       (issue_rd),
    .wb_busy  (wb_busy[MUL_BIT]),
    .idle     (unit_idle_s[MUL_BIT]),
    .wr_allow (wr_allow[MUL_BIT]),
    .rd_out   (mul_rd)
  );

  fu_tracker #(.LAT(DIV_LAT)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dispatch_start[DIV_BIT]),
    .rd       (issue_rd),
    .wb_busy  (wb_busy[DIV_BIT]),
    .idle     (unit_idle_s[DIV_BIT]),
    .wr_allow (wr_allow[DIV_BIT]),
    .rd_out   (div_rd)
  );

endmodule
